// File: rtl/hawk_wr_arb.sv
// hawk_wr_arb: round-robin arbiter that funnels cacheline writes from several
// requesters into a single AXI write master, one write in flight at a time.

package hawk_wr_arb_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RESP_W = 2;

    // Write address/data payload towards the AXI write master
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              awvalid;
        logic              wvalid;
    } axi_wr_reqpkt_t;

    // Channel ready indications from the AXI write master
    typedef struct packed {
        logic awready;
        logic wready;
    } axi_wr_rdypkt_t;

    // Write response; bready is tied high on this side
    typedef struct packed {
        logic [RESP_W-1:0] bresp;
        logic              bvalid;
    } axi_wr_resppkt_t;

endpackage

module hawk_wr_arb
    import hawk_wr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned B_TIMEOUT = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data_i,
    input  logic [NUM_REQ-1:0][STRB_W-1:0]    req_strb_i,
    output logic [NUM_REQ-1:0]                req_ack_o,
    output logic [NUM_REQ-1:0]                req_done_o,
    output logic                              req_err_o,
    output axi_wr_reqpkt_t                    wr_req_o,
    input  axi_wr_rdypkt_t                    wr_rdy_i,
    input  axi_wr_resppkt_t                   wr_resp_i,
    output logic                              busy_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (B_TIMEOUT > 1) ? $clog2(B_TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(B_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_B = 2'd2
    } state_e;

    state_e               state_q,   state_d;
    logic [IDX_W-1:0]     last_q,    last_d;
    logic [IDX_W-1:0]     owner_q,   owner_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q,  wvalid_d;
    logic [ADDR_W-1:0]    addr_q,    addr_d;
    logic [DATA_W-1:0]    data_q,    data_d;
    logic [STRB_W-1:0]    strb_q,    strb_d;
    logic [NUM_REQ-1:0]   done_q,    done_d;
    logic                 err_q,     err_d;
    logic                 busy_q,    busy_d;

    logic                 grant_vld_c;
    logic [IDX_W-1:0]     grant_idx_c;
    logic [IDX_W-1:0]     cand_c;
    logic                 grant_ok_c;
    logic                 aw_fire_c;
    logic                 w_fire_c;

    // Round-robin search starting one past the last winner, wrapping around
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand_c = IDX_W'((32'(last_q) + i) % NUM_REQ);
            if (!grant_vld_c && req_valid_i[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand_c;
            end
        end
    end

    // Grant only from IDLE, never alongside a completion pulse, never in reset
    assign grant_ok_c = rst_ni && (state_q == ST_IDLE) && !(|done_q) && grant_vld_c;

    // Accept pulse is issued in the grant cycle itself
    always_comb begin
        req_ack_o = '0;
        if (grant_ok_c) begin
            req_ack_o[grant_idx_c] = 1'b1;
        end
    end

    assign aw_fire_c = awvalid_q && wr_rdy_i.awready;
    assign w_fire_c  = wvalid_q  && wr_rdy_i.wready;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        done_d    = '0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_ok_c) begin
                    state_d   = ST_ISSUE;
                    last_d    = grant_idx_c;
                    owner_d   = grant_idx_c;
                    addr_d    = req_addr_i[grant_idx_c];
                    data_d    = req_data_i[grant_idx_c];
                    strb_d    = req_strb_i[grant_idx_c];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (aw_fire_c) begin
                    awvalid_d = 1'b0;
                end
                if (w_fire_c) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || aw_fire_c) && (!wvalid_q || w_fire_c)) begin
                    state_d = ST_WAIT_B;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_B: begin
                if (wr_resp_i.bvalid) begin
                    state_d         = ST_IDLE;
                    done_d[owner_q] = 1'b1;
                    err_d           = |wr_resp_i.bresp;
                    cnt_d           = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d         = ST_IDLE;
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any in-flight write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            last_q    <= LAST_IDX;
            owner_q   <= '0;
            cnt_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Drive the AXI write request bundle from the held payload
    always_comb begin
        wr_req_o         = '0;
        wr_req_o.addr    = addr_q;
        wr_req_o.data    = data_q;
        wr_req_o.strb    = strb_q;
        wr_req_o.awvalid = awvalid_q;
        wr_req_o.wvalid  = wvalid_q;
    end

    assign req_done_o = done_q;
    assign req_err_o  = err_q;
    assign busy_o     = busy_q;

endmodule
